// File: rtl/riscv_pkg.sv
// Shared fetch-side types and IMEM address helpers.
// Pulled in by the fetch queue and its FIFO.
package riscv_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_t;

    // A PC is fetchable when every bit above the IMEM byte-address width is zero.
    function automatic logic pc_in_range(input logic [31:0] pc, input int aw);
        return (pc >> aw) == 32'd0;
    endfunction

    function automatic logic [29:0] word_addr(input logic [31:0] pc);
        return pc[31:2];
    endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// FIFO of fetched {pc, inst} entries. The head entry comes straight from storage
// registers, so decode never sees a combinational path from IMEM data.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_clear,
    input  fetch_entry_t           i_data,
    output fetch_entry_t           o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_rd;
    logic [PW-1:0] r_wr;
    logic [PW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == FULL_CNT);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd];

    // A push into a full FIFO is only accepted when the head leaves the same cycle.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= r_wr + 1'b1;
            end
            if (w_pop) r_rd <= r_rd + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front-end: sequential PC generation, one-deep IMEM request
// pipeline with credit and epoch tracking, redirect/flush and sticky exception.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2,
    parameter int          IMEMSIZE = 131072
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_read_ready,
    output logic [29:0] mem_read_address,
    input  logic [31:0] mem_read_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        exception
);
    localparam int AW = $clog2(IMEMSIZE);
    localparam int PW = $clog2(DEPTH);

    fetch_state_t  r_state;
    fetch_state_t  w_next_state;
    logic [31:0]   r_fetch_pc;
    logic          r_epoch;
    logic          r_vld_p1;
    logic [31:0]   r_pc_p1;
    logic          r_epoch_p1;

    fetch_entry_t  w_head;
    fetch_entry_t  w_push_entry;
    logic          w_full;
    logic          w_empty;
    logic [PW:0]   w_count;
    logic [PW+1:0] w_used;
    logic          w_active;
    logic          w_redirect;
    logic          w_misaligned;
    logic          w_in_range;
    logic          w_credit_ok;
    logic          w_issue;
    logic          w_resp;
    logic          w_push;
    logic          w_pop;

    assign w_active     = (r_state != ST_HALT);
    assign w_redirect   = redirect_valid && w_active;
    assign w_misaligned = (redirect_pc[1:0] != 2'b00);
    assign w_in_range   = pc_in_range(r_fetch_pc, AW);

    // Entries held plus the response still in flight must leave room for one more.
    assign w_used      = {1'b0, w_count} + {{(PW + 1){1'b0}}, r_vld_p1};
    assign w_credit_ok = !w_full && (w_used < DEPTH[PW+1:0]);

    // Qualified by reset so the IMEM port stays idle while reset is held low.
    assign w_issue = reset && (r_state == ST_RUN) && w_in_range && w_credit_ok && !w_redirect;

    assign w_resp       = r_vld_p1 && (r_epoch_p1 == r_epoch);
    assign w_push       = w_resp && !w_redirect;
    assign w_pop        = out_valid && out_ready && !w_redirect;
    assign w_push_entry = '{pc: r_pc_p1, inst: mem_read_data};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (w_redirect),
        .i_data  (w_push_entry),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_RUN;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RUN:   if (!w_in_range) w_next_state = ST_DRAIN;
            ST_DRAIN: if (w_empty && !r_vld_p1) w_next_state = ST_HALT;
            ST_HALT:  w_next_state = ST_HALT;
            default:  w_next_state = ST_HALT;
        endcase
        if (w_redirect) w_next_state = w_misaligned ? ST_HALT : ST_RUN;
    end

    // Request stage -> response stage: the tag travels with the request so a
    // redirect can orphan a response that is already on its way back.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_pc <= RESET_PC;
            r_epoch    <= 1'b0;
            r_vld_p1   <= 1'b0;
            r_pc_p1    <= '0;
            r_epoch_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= w_issue;
            if (w_issue) begin
                r_pc_p1    <= r_fetch_pc;
                r_epoch_p1 <= r_epoch;
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_redirect) begin
                r_epoch <= ~r_epoch;
                if (!w_misaligned) r_fetch_pc <= redirect_pc;
            end
        end
    end

    assign mem_read_ready   = w_issue;
    assign mem_read_address = word_addr(r_fetch_pc);
    assign out_valid        = !w_empty && w_active;
    assign out_pc           = w_head.pc;
    assign out_inst         = w_head.inst;
    assign exception        = (r_state == ST_HALT);

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: a default instance plus a 64-byte-IMEM instance, an IMEM
// model per instance, and a scoreboard that expects a sequential PC stream.
module tb_fetch_queue;
    localparam int DEPTH = 2;

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_read_ready;
    logic [29:0] mem_read_address;
    logic [31:0] mem_read_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        exception;

    logic        s_redirect_valid;
    logic [31:0] s_redirect_pc;
    logic        s_mem_read_ready;
    logic [29:0] s_mem_read_address;
    logic [31:0] s_mem_read_data;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [31:0] s_out_pc;
    logic [31:0] s_out_inst;
    logic        s_exception;

    logic [31:0] imem [0:255];
    int n_checks = 0;
    int n_fail   = 0;

    fetch_queue dut (
        .clk              (clk),
        .reset            (reset),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .mem_read_ready   (mem_read_ready),
        .mem_read_address (mem_read_address),
        .mem_read_data    (mem_read_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_pc           (out_pc),
        .out_inst         (out_inst),
        .exception        (exception)
    );

    fetch_queue #(
        .RESET_PC (32'h0000_0038),
        .DEPTH    (DEPTH),
        .IMEMSIZE (64)
    ) dut_s (
        .clk              (clk),
        .reset            (reset),
        .redirect_valid   (s_redirect_valid),
        .redirect_pc      (s_redirect_pc),
        .mem_read_ready   (s_mem_read_ready),
        .mem_read_address (s_mem_read_address),
        .mem_read_data    (s_mem_read_data),
        .out_valid        (s_out_valid),
        .out_ready        (s_out_ready),
        .out_pc           (s_out_pc),
        .out_inst         (s_out_inst),
        .exception        (s_exception)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous IMEM: data appears the cycle after the read request.
    always @(posedge clk) begin
        if (mem_read_ready)   mem_read_data   <= imem[mem_read_address[7:0]];
        if (s_mem_read_ready) s_mem_read_data <= imem[s_mem_read_address[7:0]];
    end

    task automatic apply_reset();
        reset            = 1'b0;
        redirect_valid   = 1'b0;
        redirect_pc      = 32'h0;
        out_ready        = 1'b0;
        s_redirect_valid = 1'b0;
        s_redirect_pc    = 32'h0;
        s_out_ready      = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
        s_redirect_valid = 1'b0; s_redirect_pc = 32'h0; s_out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_out_pc: got %h want 0", out_pc); end
        n_checks++; if (out_inst !== 32'h0) begin n_fail++; $display("FAIL reset_out_inst: got %h want 0", out_inst); end
        n_checks++; if (mem_read_ready !== 1'b0) begin n_fail++; $display("FAIL reset_mem_read_ready: got %b want 0", mem_read_ready); end
        n_checks++; if (exception !== 1'b0) begin n_fail++; $display("FAIL reset_exception: got %b want 0", exception); end
        n_checks++; if (mem_read_address !== 30'h0) begin n_fail++; $display("FAIL reset_address: got %h want 0", mem_read_address); end
        n_checks++; if (s_mem_read_address !== 30'hE) begin n_fail++; $display("FAIL reset_s_address: got %h want e", s_mem_read_address); end
        @(negedge clk);
    endtask

    task automatic test_sequential();
        int first_mr = -1;
        int first_ov = -1;
        int got = 0;
        logic [31:0] exp_pc = 32'h0;
        apply_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (mem_read_ready && first_mr < 0) first_mr = c;
            if (out_valid && first_ov < 0) first_ov = c;
            if (out_valid && out_ready) begin
                n_checks++;
                if (out_pc !== exp_pc || out_inst !== imem[exp_pc[9:2]]) begin
                    n_fail++;
                    $display("FAIL seq_pair: got pc=%h inst=%h want pc=%h inst=%h", out_pc, out_inst, exp_pc, imem[exp_pc[9:2]]);
                end
                exp_pc += 32'd4;
                got++;
            end
            @(negedge clk);
        end
        n_checks++; if (first_mr !== 0) begin n_fail++; $display("FAIL seq_first_request: got cycle %0d want 0", first_mr); end
        n_checks++; if (first_ov - first_mr !== 2) begin n_fail++; $display("FAIL seq_latency: got %0d want 2", first_ov - first_mr); end
        n_checks++; if (got < 4) begin n_fail++; $display("FAIL seq_count: got %0d want >=4", got); end
    endtask

    task automatic test_backpressure();
        int issued = 0;
        int popped = 0;
        logic [31:0] exp_pc = 32'h0;
        apply_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (mem_read_ready) begin
                n_checks++;
                if (issued - popped >= DEPTH) begin n_fail++; $display("FAIL bp_credit: got occupancy %0d at issue want <%0d", issued - popped, DEPTH); end
                issued++;
            end
            @(negedge clk);
        end
        #1;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid: got %b want 1", out_valid); end
        n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL bp_hold_pc: got %h want 0", out_pc); end
        n_checks++; if (mem_read_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_no_request: got %b want 0", mem_read_ready); end
        n_checks++; if (issued !== DEPTH) begin n_fail++; $display("FAIL bp_saturate: got %0d requests want %0d", issued, DEPTH); end
        @(negedge clk);
        for (int c = 0; c < 40; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (mem_read_ready) begin
                n_checks++;
                if (issued - popped >= DEPTH) begin n_fail++; $display("FAIL bp_credit: got occupancy %0d at issue want <%0d", issued - popped, DEPTH); end
                issued++;
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (out_pc !== exp_pc || out_inst !== imem[exp_pc[9:2]]) begin
                    n_fail++;
                    $display("FAIL bp_stream: got pc=%h inst=%h want pc=%h inst=%h", out_pc, out_inst, exp_pc, imem[exp_pc[9:2]]);
                end
                exp_pc += 32'd4;
                popped++;
            end
            @(negedge clk);
        end
        n_checks++; if (popped < 5) begin n_fail++; $display("FAIL bp_progress: got %0d pops want >=5", popped); end
    endtask

    task automatic test_redirect();
        int phase = 0;
        int redir_c = -1;
        int after = 0;
        logic [31:0] exp_pc = 32'h0;
        apply_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            redirect_valid = (phase == 1);
            redirect_pc    = 32'h40;
            #1;
            if (phase == 1) begin
                n_checks++; if (mem_read_ready !== 1'b0) begin n_fail++; $display("FAIL redir_no_issue: got %b want 0", mem_read_ready); end
            end
            if (phase == 2 && c == redir_c + 1) begin
                n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_flush: got out_valid %b want 0", out_valid); end
                n_checks++; if (mem_read_address !== 30'h10) begin n_fail++; $display("FAIL redir_address: got %h want 10", mem_read_address); end
                n_checks++; if (mem_read_ready !== 1'b1) begin n_fail++; $display("FAIL redir_first_issue: got %b want 1", mem_read_ready); end
            end
            if (out_valid && out_ready && !redirect_valid) begin
                n_checks++;
                if (out_pc !== exp_pc || out_inst !== imem[exp_pc[9:2]]) begin
                    n_fail++;
                    $display("FAIL redir_stream: got pc=%h inst=%h want pc=%h inst=%h", out_pc, out_inst, exp_pc, imem[exp_pc[9:2]]);
                end
                exp_pc += 32'd4;
                if (phase == 2) after++;
            end
            if (phase == 1) begin exp_pc = 32'h40; phase = 2; redir_c = c; end
            if (phase == 0 && mem_read_ready && mem_read_address == 30'h2) phase = 1;
            @(negedge clk);
        end
        redirect_valid = 1'b0;
        n_checks++; if (after < 3) begin n_fail++; $display("FAIL redir_progress: got %0d deliveries after redirect want >=3", after); end
    endtask

    task automatic test_random_redirect();
        int occ = 0;
        int got = 0;
        logic [31:0] exp_pc = 32'h0;
        apply_reset();
        for (int c = 0; c < 300; c++) begin
            out_ready = 1'($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_pc = 32'($urandom_range(0, 255)) << 2;
            #1;
            if (redirect_valid) begin
                n_checks++; if (mem_read_ready !== 1'b0) begin n_fail++; $display("FAIL rnd_redirect_issue: got %b want 0", mem_read_ready); end
                occ = 0;
                exp_pc = redirect_pc;
            end else begin
                if (mem_read_ready) begin
                    n_checks++;
                    if (occ >= DEPTH) begin n_fail++; $display("FAIL rnd_credit: got occupancy %0d at issue want <%0d", occ, DEPTH); end
                    occ++;
                end
                if (out_valid && out_ready) begin
                    n_checks++;
                    if (out_pc !== exp_pc || out_inst !== imem[exp_pc[9:2]]) begin
                        n_fail++;
                        $display("FAIL rnd_stream: got pc=%h inst=%h want pc=%h inst=%h", out_pc, out_inst, exp_pc, imem[exp_pc[9:2]]);
                    end
                    exp_pc += 32'd4;
                    occ--;
                    got++;
                end
            end
            @(negedge clk);
        end
        redirect_valid = 1'b0;
        n_checks++; if (got < 40) begin n_fail++; $display("FAIL rnd_progress: got %0d deliveries want >=40", got); end
    endtask

    task automatic test_misaligned();
        apply_reset();
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        #1;
        n_checks++; if (exception !== 1'b0) begin n_fail++; $display("FAIL mis_early_exception: got %b want 0", exception); end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        n_checks++; if (exception !== 1'b1) begin n_fail++; $display("FAIL mis_exception: got %b want 1", exception); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mis_out_valid: got %b want 0", out_valid); end
        n_checks++; if (mem_read_ready !== 1'b0) begin n_fail++; $display("FAIL mis_request: got %b want 0", mem_read_ready); end
        @(negedge clk);
        for (int c = 0; c < 6; c++) begin
            redirect_valid = 1'b1;
            redirect_pc    = 32'h100;
            #1;
            n_checks++;
            if (mem_read_ready !== 1'b0 || exception !== 1'b1 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL halt_ignores_redirect: got ready=%b exc=%b valid=%b want 0/1/0", mem_read_ready, exception, out_valid);
            end
            @(negedge clk);
        end
        redirect_valid = 1'b0;
        #1;
        n_checks++; if (mem_read_ready !== 1'b0) begin n_fail++; $display("FAIL halt_stays: got ready %b want 0", mem_read_ready); end
        @(negedge clk);
    endtask

    task automatic test_small_imem();
        int got = 0;
        int requests = 0;
        int pop_c = -1;
        int exc_c = -1;
        logic [31:0] exp_pc = 32'h38;
        apply_reset();
        for (int c = 0; c < 30; c++) begin
            s_out_ready = (c >= 8);
            #1;
            if (c == 7) begin
                n_checks++;
                if (s_out_valid !== 1'b1 || s_out_pc !== 32'h38 || s_exception !== 1'b0) begin
                    n_fail++;
                    $display("FAIL small_hold: got valid=%b pc=%h exc=%b want 1/38/0", s_out_valid, s_out_pc, s_exception);
                end
            end
            if (s_mem_read_ready) begin
                requests++;
                n_checks++;
                if (s_mem_read_address >= 30'h10) begin n_fail++; $display("FAIL small_range: got request address %h want <10", s_mem_read_address); end
            end
            if (s_exception && exc_c < 0) exc_c = c;
            if (s_out_valid && s_out_ready) begin
                n_checks++;
                if (s_out_pc !== exp_pc || s_out_inst !== imem[exp_pc[9:2]]) begin
                    n_fail++;
                    $display("FAIL small_stream: got pc=%h inst=%h want pc=%h inst=%h", s_out_pc, s_out_inst, exp_pc, imem[exp_pc[9:2]]);
                end
                exp_pc += 32'd4;
                got++;
                pop_c = c;
            end
            @(negedge clk);
        end
        s_out_ready = 1'b0;
        #1;
        n_checks++; if (got !== 2) begin n_fail++; $display("FAIL small_count: got %0d deliveries want 2", got); end
        n_checks++; if (requests !== 2) begin n_fail++; $display("FAIL small_requests: got %0d want 2", requests); end
        n_checks++; if (s_exception !== 1'b1) begin n_fail++; $display("FAIL small_exception: got %b want 1", s_exception); end
        n_checks++; if (exc_c - pop_c !== 2) begin n_fail++; $display("FAIL small_exc_timing: got %0d cycles after last pop want 2", exc_c - pop_c); end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        logic seen = 1'b0;
        int got = 0;
        logic [31:0] exp_pc = 32'h0;
        apply_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 7 && !seen; c++) begin
            #1;
            if (mem_read_ready && c >= 3) seen = 1'b1;
            else @(negedge clk);
        end
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL areset_setup: got no request want one within budget"); end
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_inst !== 32'h0 || mem_read_ready !== 1'b0 || exception !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_outputs: got valid=%b pc=%h inst=%h ready=%b exc=%b want all 0", out_valid, out_pc, out_inst, mem_read_ready, exception);
        end
        n_checks++; if (mem_read_address !== 30'h0) begin n_fail++; $display("FAIL areset_address: got %h want 0", mem_read_address); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (out_valid && out_ready) begin
                n_checks++;
                if (out_pc !== exp_pc || out_inst !== imem[exp_pc[9:2]]) begin
                    n_fail++;
                    $display("FAIL areset_stream: got pc=%h inst=%h want pc=%h inst=%h", out_pc, out_inst, exp_pc, imem[exp_pc[9:2]]);
                end
                exp_pc += 32'd4;
                got++;
            end
            @(negedge clk);
        end
        n_checks++; if (got < 3) begin n_fail++; $display("FAIL areset_restart: got %0d deliveries want >=3", got); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit want end of test");
        $fatal(1, "time limit reached");
    end

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = $urandom;
        imem[0] = 32'h0000_0013;
        imem[1] = 32'h0010_0093;
        imem[2] = 32'h0020_0113;
        imem[3] = 32'h0030_0193;
        mem_read_data   = 32'h0;
        s_mem_read_data = 32'h0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_random_redirect();
        test_misaligned();
        test_small_imem();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Instruction fetch front-end that sits directly upstream of IF_ID.
- Generates sequential PCs and drives the synchronous instruction memory read port (read_address = pc[31:2], one-cycle read latency).
- Buffers returned {pc, instruction} pairs in a small FIFO and presents them to decode over a valid/ready handshake.
- Handles branch redirects and flushes; raises a sticky exception when fetch leaves IMEM range or a redirect target is misaligned.

Parameters:
RESET_PC, 32'h0000_0000, first PC fetched after reset release
DEPTH, 2, FIFO entries (power of 2, >=2)
IMEMSIZE, 131072, IMEM size in bytes; valid PCs satisfy pc[31:$clog2(IMEMSIZE)]==0

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
redirect_valid  in  1  branch/jump redirect from downstream, single-cycle pulse
redirect_pc  in  32  redirect target
mem_read_ready  out  1  IMEM read request this cycle
mem_read_address  out  30  IMEM word address (fetch_pc[31:2])
mem_read_data  in  32  IMEM data; valid the cycle after mem_read_ready
out_valid  out  1  head entry valid for decode
out_ready  in  1  decode accepts head entry
out_pc  out  32  PC of head entry
out_inst  out  32  instruction of head entry
exception  out  1  sticky fault/end-of-program flag

Behaviour:
- Reset (async, active low):
  - fetch_pc=RESET_PC; FIFO empty; inflight=0.
  - All outputs 0: out_valid, out_pc, out_inst, mem_read_ready, exception. mem_read_address=RESET_PC[31:2].
  - FSM=RUN.
- FSM states RUN, DRAIN, HALT:
  - RUN: issue a request when occupancy + inflight < DEPTH and fetch_pc is in range.
    - On issue: inflight<=1, remember the request pc, fetch_pc += 4 (32-bit wrap).
    - At most one request in flight; a new request may issue in the same cycle the previous one returns.
  - RUN -> DRAIN when fetch_pc is out of range; no further requests are issued.
  - DRAIN -> HALT once FIFO is empty and inflight==0. exception is asserted from the cycle HALT is entered.
  - HALT is terminal until reset. redirect_valid is ignored; out_valid=0.
- Response:
  - The cycle after issue, {request pc, mem_read_data} is pushed to the FIFO tail unless discarded by a redirect.
  - A credit reserved at issue guarantees no overflow.
- Output:
  - out_valid = FIFO not empty. out_pc/out_inst are driven from the head register (registered, no combinational path from mem_read_data).
  - Pop when out_valid && out_ready.
  - Push and pop in the same cycle are legal; occupancy is unchanged.
  - Minimum latency from issue to out_valid: 2 cycles (issue, data return/push, visible at head).
- Redirect (RUN or DRAIN), redirect_valid=1:
  - FIFO cleared and out_valid=0 next cycle. A pending response is discarded (epoch bit toggled; the response tag must match). Any simultaneous pop is void.
  - If redirect_pc[1:0]!=0: HALT next cycle, exception=1, no request issued.
  - Else: fetch_pc=redirect_pc, FSM=RUN. The first request issues the cycle after redirect. A redirect in DRAIN with an in-range target returns to RUN.
- Simultaneous redirect and data return: the data is dropped.
- No request is ever issued with an out-of-range address (mem_read_ready=0 in DRAIN/HALT).

Decomposition:
- Shared package (riscv_pkg): IMEM address helpers, RESET_PC default, fetch-entry struct {pc[31:0], inst[31:0]}.
- One sub-module: fetch_fifo (parameterised DEPTH, 64-bit entries, push/pop/clear, full/empty/count).
- fetch_queue keeps the FSM, PC, epoch and credit logic.

Test Plan:
- Reset release with IMEM words 0..3 = 00000013, 00100093, 00200113, 00300193; out_ready=1 -> pairs (0,00000013), (4,00100093), (8,00200113), (C,00300193) in order; first out_valid 2 cycles after first mem_read_ready.
- out_ready=0 for 10 cycles -> out_valid=1 with pc 0 held; occupancy saturates at DEPTH; mem_read_ready=0 while full; exactly one request outstanding at most; no entry lost or duplicated after release.
- Redirect to 0x40 while pc 0x8 in flight -> pc-0x8 data dropped; next delivered pc=0x40; next mem_read_address=0x10.
- Redirect to 0x42 -> exception=1 the next cycle, out_valid=0, mem_read_ready stays 0; later redirects ignored.
- IMEMSIZE=64, start at 0x38 -> 0x38 and 0x3C delivered; no request for 0x40; exception rises only after 0x3C is popped.
- Reset asserted mid-stream with inflight=1 -> all outputs 0 asynchronously; after release, fetch restarts at RESET_PC with no stale entry.
